// File: rtl/irq_encode8x3.sv
// irq_encode8x3: interrupt request encoder. Synchronizes eight active-low
// request lines, latches each falling edge as a pending bit, and offers the
// highest-priority enabled pending line (lowest index) to the core as vector
// code 7-i through a valid/ack handshake.
//
// SYNC_STAGES must lie in 1..3.
//
// After reset, edge capture stays disabled until the synchronizer and history
// flops have been refilled from the real inputs. This way a line that is held
// low through reset is not mistaken for a fresh falling edge: it has to return
// high and then fall again before it is captured.
module irq_encode8x3 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_n,
    input  logic [7:0] mask,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ack,
    output logic [7:0] pending
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    // The counter saturates once every synchronizer stage and the history
    // flop hold sampled input data rather than reset values.
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];
    logic [7:0] hist_q, hist_d;
    logic [2:0] warm_q, warm_d;
    logic [7:0] pending_q, pending_d;
    logic [0:0] state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [2:0] win_q, win_d;
    logic       valid_q, valid_d;

    logic [7:0] sync_s;
    logic [7:0] fall;
    logic [7:0] eligible;
    logic [7:0] clr_vec;
    logic [2:0] win_idx;
    logic       win_hit;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchronizer shift, edge history and post-reset warm-up count.
    always_comb begin
        sync_d[0] = req_n;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        hist_d = sync_s;
        warm_d = (warm_q == WARM_DONE) ? warm_q : warm_q + 3'd1;
    end

    // Falling-edge detect: history high, synchronized level now low.
    always_comb begin
        fall = (warm_q == WARM_DONE) ? (hist_q & ~sync_s) : 8'h00;
    end

    // Priority encoder over the eligible set; the lowest set index wins.
    always_comb begin
        eligible = pending_q & mask;
        win_hit  = |eligible;
        win_idx  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    // Offer FSM; an accepted offer clears its pending bit, but a capture in
    // the same cycle re-sets it.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        win_d   = win_q;
        valid_d = valid_q;
        clr_vec = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (win_hit) begin
                    code_d  = 3'd7 - win_idx;
                    win_d   = win_idx;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            default: begin
                if (ack) begin
                    clr_vec = 8'd1 << win_q;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
        pending_d = (pending_q & ~clr_vec) | fall;
    end

    // Synchronizer, history and warm-up registers; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= 8'hFF;
            end
            hist_q <= 8'hFF;
            warm_q <= 3'd0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            hist_q <= hist_d;
            warm_q <= warm_d;
        end
    end

    // Pending bits and offer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 8'h00;
            state_q   <= ST_IDLE;
            code_q    <= 3'd0;
            win_q     <= 3'd0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            state_q   <= state_d;
            code_q    <= code_d;
            win_q     <= win_d;
            valid_q   <= valid_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_encode8x3.sv
// Bench for irq_encode8x3: directed scenarios with literal expectations,
// plus a sample-history model checked against the DUT on every cycle.
module tb_irq_encode8x3;

    localparam int SS = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_n;
    logic [7:0] mask;
    logic [2:0] code;
    logic       valid;
    logic       ack;
    logic [7:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    irq_encode8x3 #(.SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_n   (req_n),
        .mask    (mask),
        .code    (code),
        .valid   (valid),
        .ack     (ack),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: samp[n] is req_n as sampled at the n-th rising edge after
    // reset release. A fall between two consecutive real samples is seen
    // as a pending bit SS+1 edges after the low sample was driven.
    logic [7:0] samp [0:4095];
    int         m_n;
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_code;
    logic [2:0] m_win;

    function automatic logic [7:0] captured_at(input int n);
        if (n - SS - 1 < 1) return 8'h00;
        return samp[n-SS-1] & ~samp[n-SS];
    endfunction

    function automatic logic [2:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n     <= 0;
            m_pend  <= 8'h00;
            m_valid <= 1'b0;
            m_code  <= 3'd0;
            m_win   <= 3'd0;
        end else begin
            m_n           <= m_n + 1;
            samp[m_n + 1] <= req_n;
            m_pend <= (m_pend & ~((m_valid && ack) ? (8'd1 << m_win) : 8'h00))
                      | captured_at(m_n + 1);
            if (m_valid) begin
                if (ack) m_valid <= 1'b0;
            end else if ((m_pend & mask) != 8'h00) begin
                m_valid <= 1'b1;
                m_win   <= lowest(m_pend & mask);
                m_code  <= 3'd7 - lowest(m_pend & mask);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Continuous compare against the model on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_pending", pending, m_pend);
            chk("cyc_valid", {7'd0, valid}, {7'd0, m_valid});
            if (m_valid) chk("cyc_code", {5'd0, code}, {5'd0, m_code});
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Literal expectation checked on both the DUT and the model.
    task automatic expect_out(input string nm, input logic v, input logic [2:0] c,
                              input logic [7:0] p);
        chk({nm, "_valid"}, {7'd0, valid}, {7'd0, v});
        chk({nm, "_pending"}, pending, p);
        chk({nm, "_model_pending"}, m_pend, p);
        if (v) begin
            chk({nm, "_code"}, {5'd0, code}, {5'd0, c});
            chk({nm, "_model_code"}, {5'd0, m_code}, {5'd0, c});
        end
    endtask

    task automatic do_ack();
        $display("ack offer code=%0d pending=%h", code, pending);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_n = 8'hFF;
        mask  = 8'hFF;
        ack   = 1'b0;
        #12;
        chk("rst_valid", {7'd0, valid}, 8'h00);
        chk("rst_code", {5'd0, code}, 8'h00);
        chk("rst_pending", pending, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(6);
        expect_out("idle", 1'b0, 3'd0, 8'h00);

        // Line 2 pulse: pending after SS+1 edges, offer one edge later.
        req_n = 8'hFB;
        tick(3);
        expect_out("l2_pend", 1'b0, 3'd0, 8'h04);
        req_n = 8'hFF;
        tick(1);
        expect_out("l2_offer", 1'b1, 3'd5, 8'h04);
        do_ack();
        expect_out("l2_ack", 1'b0, 3'd0, 8'h00);
        tick(3);

        // Lines 6 and 1 together: line 1 first, idle gap, then line 6.
        req_n = 8'hBD;
        tick(3);
        expect_out("l61_pend", 1'b0, 3'd0, 8'h42);
        req_n = 8'hFF;
        tick(1);
        expect_out("l61_first", 1'b1, 3'd6, 8'h42);
        do_ack();
        expect_out("l61_gap", 1'b0, 3'd0, 8'h40);
        tick(1);
        expect_out("l61_second", 1'b1, 3'd1, 8'h40);
        do_ack();
        expect_out("l61_done", 1'b0, 3'd0, 8'h00);
        tick(3);

        // Masked line captures but is not offered until enabled.
        mask  = 8'hFD;
        req_n = 8'hFD;
        tick(3);
        expect_out("mask_pend", 1'b0, 3'd0, 8'h02);
        req_n = 8'hFF;
        tick(3);
        expect_out("mask_hold", 1'b0, 3'd0, 8'h02);
        mask = 8'hFF;
        tick(1);
        expect_out("mask_en", 1'b1, 3'd6, 8'h02);
        do_ack();
        expect_out("mask_done", 1'b0, 3'd0, 8'h00);
        tick(3);

        // Offer for line 4 is not preempted by line 0 or by mask changes.
        req_n = 8'hEF;
        tick(4);
        expect_out("pre_offer", 1'b1, 3'd3, 8'h10);
        req_n = 8'hFE;
        mask  = 8'h00;
        tick(1);
        expect_out("pre_mask", 1'b1, 3'd3, 8'h10);
        mask = 8'hFF;
        tick(2);
        expect_out("pre_cap", 1'b1, 3'd3, 8'h11);
        req_n = 8'hFF;
        tick(2);
        expect_out("pre_hold", 1'b1, 3'd3, 8'h11);
        do_ack();
        expect_out("pre_ack", 1'b0, 3'd0, 8'h01);
        tick(1);
        expect_out("pre_next", 1'b1, 3'd7, 8'h01);
        do_ack();
        expect_out("pre_done", 1'b0, 3'd0, 8'h00);
        tick(3);

        // Re-capture of line 5 in the same cycle its ack clears it.
        req_n = 8'hDF;
        tick(4);
        expect_out("l5_offer", 1'b1, 3'd2, 8'h20);
        req_n = 8'hFF;
        tick(1);
        req_n = 8'hDF;
        tick(2);
        do_ack();
        expect_out("l5_setwins", 1'b0, 3'd0, 8'h20);
        tick(1);
        expect_out("l5_reoffer", 1'b1, 3'd2, 8'h20);
        req_n = 8'hFF;
        do_ack();
        expect_out("l5_done", 1'b0, 3'd0, 8'h00);
        tick(3);

        // Reset mid-offer; line 3 held low through reset is not re-captured.
        req_n = 8'hF7;
        tick(4);
        expect_out("rst_offer", 1'b1, 3'd4, 8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {7'd0, valid}, 8'h00);
        chk("midrst_code", {5'd0, code}, 8'h00);
        chk("midrst_pending", pending, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        expect_out("held_low", 1'b0, 3'd0, 8'h00);
        req_n = 8'hFF;
        tick(1);
        req_n = 8'hF7;
        tick(3);
        expect_out("l3_recap", 1'b0, 3'd0, 8'h08);
        tick(1);
        expect_out("l3_offer", 1'b1, 3'd4, 8'h08);
        req_n = 8'hFF;
        do_ack();
        expect_out("l3_done", 1'b0, 3'd0, 8'h00);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_encode8x3.md
# irq_encode8x3

Interrupt request encoder for the CPU's interrupt path. It takes eight active-low, asynchronous request lines and captures each falling edge as a pending bit. It then priority-encodes the enabled pending bits into a 3-bit vector code and offers that code to the core through a valid/ack handshake. Its code mapping is the inverse of the design's active-low 3-to-8 line decoder: request line i maps to code 7−i, so feeding `code` back through that decoder drives line i low.

## Interface
- `SYNC_STAGES`, default 2: input synchronizer depth per request line; legal range 1–3.

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_n`  in  8  request lines, active-low, asynchronous to `clk`
- `mask`  in  8  per-line enable, 1 = enabled; synchronous to `clk`
- `code`  out  3  offered vector code; meaningful only while `valid` = 1
- `valid`  out  1  offer present
- `ack`  in  1  core accepts the current offer
- `pending`  out  8  raw pending bits, unmasked, for status readout

## Operation
- Reset values: `code` = 0, `valid` = 0, `pending` = 0x00. Every synchronizer flop and the edge-detect history flop reset to 1 (the idle level).
- Synchronizer: each `req_n[i]` passes through `SYNC_STAGES` flops. `s[i]` is the last stage and `h[i]` is `s[i]` delayed by one cycle.
- Capture: `pending[i]` sets on the cycle where `h[i]` = 1 and `s[i]` = 0 (a falling edge).
  - Holding a line low produces exactly one capture.
  - A new capture requires the line to return high first.
- Priority: the eligible set is `pending & mask`. The lowest set index i wins, which is the highest code. The winner's code is 7−i.
- FSM, two states:
  - IDLE: `valid` = 0. If the eligible set is non-empty, register `code` = 7−i and the winner index, set `valid` = 1, and go to OFFER.
  - OFFER: `code` and `valid` are held stable. Mask changes, new captures and higher-priority arrivals do not alter or retract the offer. On `ack` = 1: clear `pending[winner]`, drive `valid` = 0, and go to IDLE.
- `ack` is ignored in IDLE.
- If a capture on line i and an ack clearing line i occur in the same cycle, the set wins: `pending[i]` stays 1.
- A masked line still captures and shows in `pending`. It becomes eligible as soon as its mask bit is 1.
- If reset asserts mid-offer, all state returns immediately to its reset value and any in-flight offer is lost.

## Timing
- Falling edge on `req_n[i]` to `pending[i]` = 1: `SYNC_STAGES` + 1 rising edges (plus up to one cycle of input skew).
- `pending` visible, in IDLE, eligible → `valid` = 1: one edge later. Total input-to-`valid` latency is `SYNC_STAGES` + 2 edges.
- Ack sampled at edge k:
  - `valid` = 0 and the pending bit is cleared after edge k.
  - The earliest next offer is after edge k+1, so consecutive offers are separated by at least one idle cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset with `req_n` = 0xFF and `mask` = 0xFF, then pulse `req_n[2]` low for 3 cycles → `pending` = 0x04. Four edges after the fall, `valid` = 1 and `code` = 5. Ack one cycle → `valid` = 0 and `pending` = 0x00.
- Drop `req_n[6]` and `req_n[1]` in the same cycle → first offer `code` = 6. After ack, a one-cycle gap, then `code` = 1. After the second ack, `pending` = 0x00.
- With `mask` = 0xFD, pulse `req_n[1]` → `pending` = 0x02 and `valid` stays 0. Set `mask` = 0xFF → `valid` = 1 with `code` = 6.
- While offering `code` = 3 (line 4), capture line 0 → the offer stays `code` = 3 until ack. The next offer is `code` = 7.
- Hold `req_n[5]` low across an ack, then pulse it high and low again in the cycle its ack clears it → `pending[5]` stays 1 and the line is re-offered with `code` = 2.
- Assert `rst_n` = 0 mid-offer → `valid`, `code` and `pending` go to 0 immediately. Holding `req_n[3]` low through reset produces no capture until the line rises and falls again.
